// File: rtl/lfsr_grant_scheduler_if.sv
// Requester-side bus of the LFSR grant scheduler: request levels in,
// one-hot grant pulses with the delivered random word out.
interface lfsr_grant_scheduler_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0] req;
    logic [NREQ-1:0] gnt;
    logic            rnd_valid;
    logic [15:0]     rnd_data;
    logic            period_wrap;

    modport master (
        output req,
        input  gnt, rnd_valid, rnd_data, period_wrap
    );

    modport slave (
        input  req,
        output gnt, rnd_valid, rnd_data, period_wrap
    );
endinterface

// File: rtl/lfsr_grant_scheduler.sv
// Round-robin arbiter that hands one fresh 16-bit Galois LFSR word to each
// granted requester; the LFSR advances only on a grant.
module lfsr_grant_scheduler #(
    parameter int          NREQ = 4,
    parameter logic [15:0] SEED = 16'hACE1,
    parameter logic [15:0] TAPS = 16'hB400
) (
    input  logic        CLK,
    input  logic        rstb,
    input  logic        hold,
    input  logic        seed_load,
    input  logic [15:0] seed_in,
    output logic        seed_err,
    lfsr_grant_scheduler_if.slave bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {RUN, HOLD, LOAD} mode_t;

    mode_t             w_mode;
    logic [15:0]       r_s;
    logic [PW-1:0]     r_ptr;
    logic [15:0]       r_cnt;
    logic [NREQ-1:0]   r_gnt;
    logic              r_valid;
    logic [15:0]       r_data;
    logic              r_wrap;
    logic              r_serr;

    logic [NREQ-1:0]   w_elig;
    logic [2*NREQ-1:0] w_dbl;
    logic [NREQ-1:0]   w_rot;
    logic              w_found;
    logic [PW:0]       w_sum;
    logic [PW-1:0]     w_win;
    logic [PW-1:0]     w_ptr_next;
    logic [15:0]       w_s_next;
    logic              w_adv;
    logic              w_last;
    logic [NREQ-1:0]   w_gnt_d;

    // Mode is decided afresh every cycle; there is no multi-cycle sequence.
    always_comb begin
        w_mode = RUN;
        if (seed_load)
            w_mode = LOAD;
        else if (hold)
            w_mode = HOLD;
    end

    // Rotate eligibility so bit 0 is the pointer position, take the first
    // set bit, then map its offset back to an absolute requester index.
    always_comb begin
        w_elig  = bus.req & ~r_gnt;
        w_dbl   = {w_elig, w_elig} >> r_ptr;
        w_rot   = w_dbl[NREQ-1:0];
        w_found = 1'b0;
        w_sum   = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && w_rot[i]) begin
                w_found = 1'b1;
                w_sum   = {1'b0, r_ptr} + (PW+1)'(i);
            end
        end
        if (w_sum >= (PW+1)'(NREQ))
            w_win = PW'(w_sum - (PW+1)'(NREQ));
        else
            w_win = PW'(w_sum);
        w_ptr_next = (w_win == PW'(NREQ - 1)) ? '0 : w_win + 1'b1;
        w_s_next   = (r_s >> 1) ^ (r_s[0] ? TAPS : '0);
    end

    always_comb begin
        w_adv   = (w_mode == RUN) && w_found;
        w_last  = (r_cnt == 16'hFFFE);
        w_gnt_d = w_adv ? (NREQ'(1) << w_win) : '0;
    end

    always_ff @(posedge CLK) begin
        if (!rstb) begin
            r_s     <= SEED;
            r_ptr   <= '0;
            r_cnt   <= '0;
            r_gnt   <= '0;
            r_valid <= 1'b0;
            r_data  <= '0;
            r_wrap  <= 1'b0;
            r_serr  <= 1'b0;
        end else begin
            r_gnt   <= w_gnt_d;
            r_valid <= w_adv;
            r_wrap  <= w_adv && w_last;
            r_serr  <= (w_mode == LOAD) && (seed_in == '0);
            if (w_mode == LOAD) begin
                r_s   <= (seed_in == '0) ? SEED : seed_in;
                r_cnt <= '0;
            end else if (w_adv) begin
                r_data <= r_s;
                r_s    <= w_s_next;
                r_ptr  <= w_ptr_next;
                r_cnt  <= w_last ? '0 : r_cnt + 16'd1;
            end
        end
    end

    assign bus.gnt         = r_gnt;
    assign bus.rnd_valid   = r_valid;
    assign bus.rnd_data    = r_data;
    assign bus.period_wrap = r_wrap;
    assign seed_err        = r_serr;
endmodule

// File: tb/tb_lfsr_grant_scheduler.sv
// Directed bench for lfsr_grant_scheduler with a cycle-level reference model
// compared against the DUT after every rising edge.
module tb_lfsr_grant_scheduler;
    localparam int NREQ = 4;

    logic        CLK = 1'b0;
    logic        rstb;
    logic        hold;
    logic        seed_load;
    logic [15:0] seed_in;
    logic        seed_err;

    lfsr_grant_scheduler_if #(.NREQ(NREQ)) bus ();

    lfsr_grant_scheduler #(.NREQ(NREQ), .SEED(16'hACE1), .TAPS(16'hB400)) dut (
        .CLK      (CLK),
        .rstb     (rstb),
        .hold     (hold),
        .seed_load(seed_load),
        .seed_in  (seed_in),
        .seed_err (seed_err),
        .bus      (bus)
    );

    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return (s >> 1) ^ ((s % 2 == 1) ? 16'hB400 : 16'h0000);
    endfunction

    // Reference model: plain integers for pointer/count, one-hot grant.
    logic [15:0] m_s = 16'hACE1;
    int          m_ptr = 0;
    int          m_cnt = 0;
    logic [3:0]  m_gnt = '0;
    logic        m_valid = 1'b0;
    logic [15:0] m_data = '0;
    logic        m_wrap = 1'b0;
    logic        m_serr = 1'b0;
    logic [3:0]  m_elig;
    int          m_w;

    always @(posedge CLK) begin
        if (!rstb) begin
            m_s = 16'hACE1; m_ptr = 0; m_cnt = 0; m_gnt = '0;
            m_valid = 0; m_data = '0; m_wrap = 0; m_serr = 0;
        end else if (seed_load) begin
            m_s    = (seed_in == 0) ? 16'hACE1 : seed_in;
            m_serr = (seed_in == 0);
            m_cnt  = 0; m_gnt = '0; m_valid = 0; m_wrap = 0;
        end else if (hold) begin
            m_gnt = '0; m_valid = 0; m_wrap = 0; m_serr = 0;
        end else begin
            m_elig = bus.req & ~m_gnt;
            m_w = -1;
            for (int k = 0; k < NREQ; k++)
                if (m_w < 0 && m_elig[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
            m_serr = 0;
            if (m_w >= 0) begin
                m_gnt   = 4'(1 << m_w);
                m_valid = 1;
                m_data  = m_s;
                m_s     = lfsr_step(m_s);
                m_ptr   = (m_w + 1) % NREQ;
                m_cnt   = m_cnt + 1;
                m_wrap  = (m_cnt == 65535);
                if (m_cnt == 65535) m_cnt = 0;
            end else begin
                m_gnt = '0; m_valid = 0; m_wrap = 0;
            end
        end
        #1;
        chk("gnt",         32'(bus.gnt),         32'(m_gnt));
        chk("rnd_valid",   32'(bus.rnd_valid),   32'(m_valid));
        chk("rnd_data",    32'(bus.rnd_data),    32'(m_data));
        chk("period_wrap", 32'(bus.period_wrap), 32'(m_wrap));
        chk("seed_err",    32'(seed_err),        32'(m_serr));
    end

    task automatic tick();
        @(negedge CLK);
    endtask

    bit          seen [0:65535];
    logic [15:0] seq1 [4];
    logic [15:0] seq2 [5];
    logic [3:0]  gseq [5];
    logic [15:0] h_data;
    logic [15:0] h_next;
    int          wraps;

    initial begin
        seq1 = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
        seq2 = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C, 16'h1C4E};
        gseq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rstb = 0; hold = 0; seed_load = 0; seed_in = '0; bus.req = '0;
        tick(); tick();
        chk("reset_gnt",   32'(bus.gnt),       32'h0);
        chk("reset_valid", 32'(bus.rnd_valid), 32'h0);
        chk("reset_data",  32'(bus.rnd_data),  32'h0);

        // Single requester: granted every other cycle.
        rstb = 1; bus.req = 4'b0001;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (i % 2 == 0) begin
                chk("single_gnt",  32'(bus.gnt),      32'h1);
                chk("single_data", 32'(bus.rnd_data), 32'(seq1[i/2]));
            end else begin
                chk("single_gap", 32'(bus.gnt), 32'h0);
            end
        end
        tick();
        chk("pre_reset_gnt", 32'(bus.gnt), 32'h1);

        // Reset mid-grant, then full load rotation.
        rstb = 0;
        tick();
        chk("midrst_gnt",   32'(bus.gnt),       32'h0);
        chk("midrst_valid", 32'(bus.rnd_valid), 32'h0);
        chk("midrst_data",  32'(bus.rnd_data),  32'h0);
        rstb = 1; bus.req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rot_gnt",  32'(bus.gnt),      32'(gseq[i]));
            chk("rot_data", 32'(bus.rnd_data), 32'(seq2[i]));
        end
        tick(); tick();

        // Hold freezes grants and the word stream.
        bus.req = 4'b0110;
        tick(); tick();
        h_data = m_data; h_next = m_s;
        hold = 1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("hold_gnt",  32'(bus.gnt),      32'h0);
            chk("hold_data", 32'(bus.rnd_data), 32'(h_data));
        end
        hold = 0;
        tick();
        chk("resume_valid", 32'(bus.rnd_valid), 32'h1);
        chk("resume_data",  32'(bus.rnd_data),  32'(h_next));
        tick(); tick();

        // Zero seed rejected, non-zero seed taken.
        bus.req = 4'b0001; seed_load = 1; seed_in = 16'h0000;
        tick();
        chk("zseed_err", 32'(seed_err), 32'h1);
        chk("zseed_gnt", 32'(bus.gnt),  32'h0);
        seed_load = 0;
        tick();
        chk("zseed_word",  32'(bus.rnd_data), 32'hACE1);
        chk("zseed_err_0", 32'(seed_err),     32'h0);
        seed_load = 1; seed_in = 16'h1234;
        tick();
        chk("seed_err_nz", 32'(seed_err), 32'h0);
        chk("seed_gnt",    32'(bus.gnt),  32'h0);
        seed_load = 0;
        tick();
        chk("seed_w0", 32'(bus.rnd_data), 32'h1234);
        tick();
        tick();
        chk("seed_w1", 32'(bus.rnd_data), 32'h091A);

        // seed_load beats hold.
        hold = 1; seed_load = 1; seed_in = 16'hBEEF;
        tick();
        hold = 0; seed_load = 0;
        tick();
        chk("loadhold_gnt",  32'(bus.gnt),      32'h1);
        chk("loadhold_data", 32'(bus.rnd_data), 32'hBEEF);

        // Full period under full load.
        rstb = 0; bus.req = 4'b1111;
        tick();
        rstb = 1;
        for (int i = 0; i < 65536; i++) seen[i] = 0;
        wraps = 0;
        for (int g = 1; g <= 65535; g++) begin
            tick();
            chk("period_valid", 32'(bus.rnd_valid), 32'h1);
            chk("no_repeat", 32'(seen[bus.rnd_data]), 32'h0);
            seen[bus.rnd_data] = 1;
            if (g < 65535) begin
                if (bus.period_wrap) wraps++;
            end else begin
                chk("wrap_pulse", 32'(bus.period_wrap), 32'h1);
            end
        end
        chk("early_wraps", 32'(wraps), 32'h0);
        tick();
        chk("after_wrap_data",  32'(bus.rnd_data),    32'hACE1);
        chk("after_wrap_pulse", 32'(bus.period_wrap), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lfsr_grant_scheduler.md
# lfsr_grant_scheduler

Shares one 16-bit Galois LFSR random source among NREQ requesters using round-robin arbitration, handing exactly one fresh word to each granted requester. It owns the LFSR state, advances it only on a grant, supports run-time reseeding with zero-seed protection, and flags completion of each full 65535-word period. It sits between the random source and its consumers (scramblers, test-pattern generators) in the CLK domain.

## Interface

- NREQ, 4, number of requesters (2..8)
- SEED, 16'hACE1, reset/default seed (must be nonzero)
- TAPS, 16'hB400, Galois feedback mask (x^16+x^14+x^13+x^11+1, maximal length)

- CLK  in  1  system clock, all logic on rising edge
- rstb  in  1  synchronous, active-low reset
- hold  in  1  1 = freeze: no grants, LFSR and counters static
- seed_load  in  1  1-cycle strobe: load seed_in
- seed_in  in  16  new seed value
- req  in  NREQ  request per requester, level
- gnt  out  NREQ  one-hot grant pulse, registered
- rnd_valid  out  1  high exactly when any gnt bit high
- rnd_data  out  16  word delivered with gnt; holds last value otherwise
- period_wrap  out  1  1-cycle pulse after 65535th advance since last seed
- seed_err  out  1  1-cycle pulse when a zero seed was rejected

## Operation

- LFSR step: lsb = s[0]; s_next = (s >> 1) ^ (lsb ? TAPS : 0). From ACE1: E270, 7138, 389C, ...
- States: RUN (normal), HOLD (hold=1), LOAD (seed_load=1). Priority each cycle: LOAD > HOLD > RUN. State is combinational from inputs each cycle; no multi-cycle sequences.
- RUN: eligible = req & ~gnt (requester granted this cycle is masked for one cycle). Winner = first eligible bit at or after pointer ptr, searching upward with wrap at NREQ-1 -> 0. If winner exists, next edge: gnt[w]=1, rnd_valid=1, rnd_data=s (current state, pre-advance), s<=s_next, ptr<=(w+1) mod NREQ, cnt<=cnt+1. No eligible request: gnt=0, nothing advances.
- HOLD: gnt=0, rnd_valid=0, s/ptr/cnt unchanged; pending requests wait, nothing lost.
- LOAD: s<=(seed_in==0) ? SEED : seed_in; seed_err<=(seed_in==0); cnt<=0; gnt=0 that cycle; ptr unchanged.
- Period: cnt 16-bit count of advances; when an advance makes cnt reach 65535, cnt<=0 and period_wrap pulses with that grant; s equals the seed again.
- rnd_data only updates on grants; otherwise holds.
- Single continuously asserted requester: granted every other cycle. All NREQ asserted: grants rotate 0,1,..,NREQ-1, one per cycle.

## Timing

- Reset (rstb=0 at edge): s=SEED, ptr=0, cnt=0, gnt=0, rnd_valid=0, rnd_data=0, period_wrap=0, seed_err=0. Reset overrides all inputs; reset mid-grant clears gnt on that edge.
- Latency req -> gnt: 1 cycle (req high at edge k-1 setup -> gnt high after edge k) when eligible and ptr favours it; worst case NREQ-1 additional cycles under full load.
- gnt, rnd_valid, rnd_data, period_wrap, seed_err all registered; change only on CLK rising edge.
- Requester consumes rnd_data in the cycle gnt is high; must drop req that cycle if it wants no further word (masking ensures no double-grant from a stale req).
- seed_load and hold high together: LOAD wins. seed_load on the same cycle as an otherwise-winning req: no grant; req is served next RUN cycle with the new seed's first word (the seed itself).
- Wrap: period_wrap coincides with the grant carrying the 65535th word.

## Test plan

- Reset, req=4'b0001 held: gnt 0001 every other cycle, rnd_data sequence ACE1, E270, 7138, 389C.
- req=4'b1111 held after reset: gnt 0001,0010,0100,1000,0001...; rnd_data ACE1, E270, 7138, 389C, 1C4E on consecutive cycles.
- hold=1 for 5 cycles mid-stream with req=4'b0110: no gnt, rnd_data frozen; after release rotation resumes at the saved ptr with the next unused word.
- seed_load with seed_in=16'h0000: seed_err pulses once, next word delivered is ACE1; seed_in=16'h1234: next word 1234, then 091A.
- req=4'b1111 for 65535 grants from reset: period_wrap pulses exactly once with the 65535th grant, next word ACE1, no word repeats before it.
- rstb=0 for one cycle during active grants: all outputs 0 next cycle, first post-reset grant goes to lowest requesting index with rnd_data ACE1.
